mul_shift_add: RTL and testbench

//   Sequential unsigned shift-and-add multiplier. It is the inverse-operation companion to the

---
 rtl/alu_pkg.sv | 16 +
 rtl/mul_step.sv | 16 +
 rtl/mul_shift_add.sv | 113 +++++++++++
 tb/tb_mul_shift_add.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// State encoding shared by the PB-V ALU sequential units (multiplier and divider).
package alu_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StLoad = LOAD,
    StRun  = RUN,
    StDone = DONE
  } alu_state_e;

endpackage

// File: rtl/mul_step.sv
// One shift-and-add step: add the multiplicand to the high half when the current multiplier
// bit is set, keeping the carry.
module mul_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] hi,
  input  logic             lo_bit,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH:0]   sum
);

  always_comb begin
    sum = {1'b0, hi} + (lo_bit ? {1'b0, mcand} : {(WIDTH + 1){1'b0}});
  end

endmodule

// File: rtl/mul_shift_add.sv
// Sequential unsigned shift-and-add multiplier, WIDTH iterations of one WIDTH-bit add,
// using the same start/done handshake as the restoring divider.
module mul_shift_add
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  alu_state_e           state_q, state_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [2*WIDTH-1:0]   p_step;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     result_hi_q, result_hi_d;
  logic                 overflow_q, overflow_d;

  mul_step #(
    .WIDTH (WIDTH)
  ) u_mul_step (
    .hi     (p_q[2*WIDTH-1:WIDTH]),
    .lo_bit (p_q[0]),
    .mcand  (mcand_q),
    .sum    (sum)
  );

  // The carry re-enters as the MSB, so the add and the right shift happen together.
  assign p_step = {sum, p_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mcand_d     = mcand_q;
    p_d         = p_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        mcand_d = a;
        p_d     = {{WIDTH{1'b0}}, b};
        count_d = '0;
        state_d = StRun;
      end
      StRun: begin
        p_d = p_step;
        if (count_q == CntLast) begin
          // Outputs only change on entry to DONE and then hold through IDLE.
          state_d     = StDone;
          result_d    = p_step[WIDTH-1:0];
          result_hi_d = p_step[2*WIDTH-1:WIDTH];
          overflow_d  = |p_step[2*WIDTH-1:WIDTH];
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      StDone: begin
        if (!start) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      mcand_q     <= '0;
      p_q         <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mcand_q     <= mcand_d;
      p_q         <= p_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      overflow_q  <= overflow_d;
    end
  end

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q == StLoad) || (state_q == StRun);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_mul_shift_add.sv
// Directed bench for mul_shift_add: products, latency, handshake, reset abort, operand latching.
module tb_mul_shift_add;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         overflow;
  logic         busy;
  logic         done;

  int n_tests;
  int n_fail;
  int done_rises;
  int both_high;
  logic done_prev;

  mul_shift_add #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .result    (result),
    .result_hi (result_hi),
    .overflow  (overflow),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    done_prev <= done;
    if (done && !done_prev) done_rises <= done_rises + 1;
    if (busy && done) both_high <= both_high + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request, measure edges until done, check outputs, then hold/drop start.
  task automatic run_mul(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                         input logic exp_ov, input int hold);
    int cyc;
    @(negedge clk);
    a     = ta;
    b     = tb;
    start = 1'b1;
    cyc   = 0;
    while (!done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, " latency"}, cyc, W + 2);
    check({tag, " result"}, result, exp_lo);
    check({tag, " result_hi"}, result_hi, exp_hi);
    check({tag, " overflow"}, overflow, exp_ov);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, " done held"}, done, 1'b1);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " done falls"}, done, 1'b0);
    check({tag, " result holds"}, result, exp_lo);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    done_rises = 0;
    both_high  = 0;
    done_prev  = 1'b0;
    reset      = 1'b1;
    start      = 1'b0;
    a          = '0;
    b          = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset result", {result_hi, result}, 16'h0000);
    check("reset overflow", overflow, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    run_mul("16x4", 8'd16, 8'd4, 8'd64, 8'd0, 1'b0, 3);
    run_mul("10x2", 8'd10, 8'd2, 8'd20, 8'd0, 1'b0, 0);
    run_mul("15x3", 8'd15, 8'd3, 8'd45, 8'd0, 1'b0, 0);
    run_mul("255x255", 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 0);
    run_mul("0x200", 8'd0, 8'd200, 8'd0, 8'd0, 1'b0, 0);
    run_mul("200x0", 8'd200, 8'd0, 8'd0, 8'd0, 1'b0, 0);
    run_mul("128x2", 8'd128, 8'd2, 8'd0, 8'd1, 1'b1, 0);

    // Reset during RUN after a non-zero result is already latched.
    run_mul("13x11", 8'd13, 8'd11, 8'd143, 8'd0, 1'b0, 0);
    @(negedge clk);
    a     = 8'd99;
    b     = 8'd77;
    start = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("pre-reset busy", busy, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort result", {result_hi, result}, 16'h0000);
    check("abort overflow", overflow, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    run_mul("7x9 after reset", 8'd7, 8'd9, 8'd63, 8'd0, 1'b0, 0);

    // Operands and start change during RUN; LOAD-time operands must win.
    done_rises = 0;
    @(negedge clk);
    a     = 8'd12;
    b     = 8'd11;
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk);
      #1;
    end
    check("latch result", result, 8'd132);
    check("latch result_hi", result_hi, 8'd0);
    repeat (15) @(posedge clk);
    #1;
    check("single done episode", done_rises, 1);
    check("busy/done exclusive", both_high, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
